// File: rtl/md_ctrl.sv
// md_ctrl - multi-cycle multiply/divide controller for the five-stage pipeline.
//
// Accepts mult/multu/div/divu/mthi/mtlo (and madd/maddu when MD_MADD_EN is
// defined) from the E stage. Long operations compute their result at
// acceptance, hold it in pending registers while busy for a fixed latency,
// then commit it to the architectural HI/LO registers. mthi/mtlo write HI/LO
// directly with no busy cycles. A D-stage stall is requested whenever a
// HI/LO-using instruction in D would collide with an operation in flight.
//
// Optional feature macro: MD_MADD_EN (ops 6/7 accumulate into {HI,LO}).
// Without it, ops 6/7 are no-ops.
//
// Ports:
//   clk       in   clock, rising-edge
//   reset     in   asynchronous active-high reset
//   start_E   in   valid HI/LO operation in E (already flush-qualified)
//   md_op_E   in   [2:0] 0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 madd,7 maddu
//   src_a_E   in   [31:0] rs value
//   src_b_E   in   [31:0] rt value
//   md_use_D  in   instruction in D uses the multiply/divide unit
//   busy      out  operation in flight
//   done      out  one-cycle pulse in the last busy cycle
//   stall_md  out  D-stage stall request
//   hi_out    out  [31:0] architectural HI
//   lo_out    out  [31:0] architectural LO
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        done,
  output logic        stall_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
  logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic        pend_wr, pend_wr_nxt;
  logic        is_long;
  logic        is_div;
  logic [64:0] calc;

  // Result of a long op as {write_enable, hi, lo}. A divide by zero clears the
  // write enable so HI/LO keep their prior values at completion.
  function automatic logic [64:0] md_calc(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic signed [63:0] a_s, b_s, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] num_s, den_s, quo_s, rem_s;
    logic [31:0]        den_u;
    logic               ovf;
    a_s    = {{32{a[31]}}, a};
    b_s    = {{32{b[31]}}, b};
    prod_s = a_s * b_s;
    prod_u = {32'd0, a} * {32'd0, b};
    // The one signed quotient that does not fit in 32 bits wraps to the
    // dividend with a zero remainder; the divider sees a safe operand instead.
    ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    num_s  = a;
    den_s  = (b == 32'd0 || ovf) ? 32'sd1 : b;
    den_u  = (b == 32'd0) ? 32'd1 : b;
    quo_s  = ovf ? 32'sh8000_0000 : (num_s / den_s);
    rem_s  = ovf ? 32'sd0 : (num_s % den_s);
    case (op)
      3'd0:    md_calc = {1'b1, prod_s};
      3'd1:    md_calc = {1'b1, prod_u};
      3'd2:    md_calc = (b == 32'd0) ? {1'b0, hi, lo} : {1'b1, rem_s, quo_s};
      3'd3:    md_calc = (b == 32'd0) ? {1'b0, hi, lo} : {1'b1, a % den_u, a / den_u};
`ifdef MD_MADD_EN
      3'd6:    md_calc = {1'b1, {hi, lo} + prod_s};
      3'd7:    md_calc = {1'b1, {hi, lo} + prod_u};
`endif
      default: md_calc = {1'b0, hi, lo};
    endcase
  endfunction

  always_comb begin
    case (md_op_E)
      3'd0, 3'd1, 3'd2, 3'd3: is_long = 1'b1;
`ifdef MD_MADD_EN
      3'd6, 3'd7:             is_long = 1'b1;
`endif
      default:                is_long = 1'b0;
    endcase
  end

  assign is_div = (md_op_E == 3'd2) || (md_op_E == 3'd3);
  assign calc   = md_calc(md_op_E, src_a_E, src_b_E, hi_q, lo_q);

  // Next-state and output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_wr_nxt = pend_wr;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start_E) begin
          if (is_long) begin
            pend_wr_nxt = calc[64];
            pend_hi_nxt = calc[63:32];
            pend_lo_nxt = calc[31:0];
            cnt_nxt     = is_div ? DIV_LD : MULT_LD;
            state_nxt   = RUN;
          end else if (md_op_E == 3'd4) begin
            hi_nxt = src_a_E;
          end else if (md_op_E == 3'd5) begin
            lo_nxt = src_a_E;
          end
        end
      end
      RUN: begin
        // start_E here is a protocol violation and deliberately ignored
        cnt_nxt = cnt - 5'd1;
        if (cnt == 5'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
          if (pend_wr) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      pend_wr <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_wr <= pend_wr_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  assign busy     = (state == RUN);
  assign stall_md = md_use_D & (busy | (start_E & is_long));
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
